// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared definitions for the DDR3 SDRAM responder and its controller.
//   - command encodings ({cs_bar,ras_bar,cas_bar,we_bar}) and decoder
//   - error cause codes
//   - mode-register decode helpers (CL, AL)
//   - burst word-index helper
package ddr3_pkg;

    localparam int DQ_W       = 16;
    localparam int BE_W       = DQ_W / 8;
    localparam int WORD_IDX_W = 11;   // {BA(3), row(2), col_hi(3), col_lo(3)}

    localparam logic [4:0] CL_RESET = 5'd5;

    typedef enum logic [3:0] {
        CMD_MRS  = 4'b0000,
        CMD_PRE  = 4'b0010,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_ZQCS = 4'b0110,
        CMD_NOP  = 4'b0111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'b000,
        ERR_IDLE_BANK  = 3'b001,
        ERR_ACT_ACTIVE = 3'b010,
        ERR_OVERLAP    = 3'b011,
        ERR_MRS_ACTIVE = 3'b100
    } err_e;

    typedef enum logic [1:0] {
        BST_IDLE,
        BST_RD,
        BST_WR
    } bst_e;

    // Deselect and any unlisted encoding (e.g. refresh) fall through to NOP.
    function automatic cmd_e decode_cmd(input logic cs_bar, input logic ras_bar,
                                        input logic cas_bar, input logic we_bar);
        logic [3:0] raw;
        raw = {cs_bar, ras_bar, cas_bar, we_bar};
        decode_cmd = CMD_NOP;
        if (!cs_bar) begin
            case (raw)
                4'b0000: decode_cmd = CMD_MRS;
                4'b0010: decode_cmd = CMD_PRE;
                4'b0011: decode_cmd = CMD_ACT;
                4'b0100: decode_cmd = CMD_WR;
                4'b0101: decode_cmd = CMD_RD;
                4'b0110: decode_cmd = CMD_ZQCS;
                default: decode_cmd = CMD_NOP;
            endcase
        end
    endfunction

    // MR0 A[6:4]: 001..110 -> CL 5..10; reserved codes keep the current CL.
    function automatic logic [4:0] cl_decode(input logic [2:0] code, input logic [4:0] cur);
        if (code >= 3'd1 && code <= 3'd6)
            cl_decode = {2'b00, code} + 5'd4;
        else
            cl_decode = cur;
    endfunction

    // MR1 A[4:3]: AL follows the current CL so a later MR0 write keeps them consistent.
    function automatic logic [4:0] al_decode(input logic [1:0] mode, input logic [4:0] cl);
        case (mode)
            2'b01:   al_decode = cl - 5'd1;
            2'b10:   al_decode = cl - 5'd2;
            default: al_decode = 5'd0;
        endcase
    endfunction

    // Burst beat address: BL8 wraps on col[2:0], BC4 holds col[2] and wraps on col[1:0].
    function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [2:0] ba,
                                                       input logic [1:0] row,
                                                       input logic [5:0] col,
                                                       input logic [2:0] beat,
                                                       input logic       bc4);
        logic [2:0] lo;
        if (bc4)
            lo = {col[2], col[1:0] + beat[1:0]};
        else
            lo = col[2:0] + beat;
        word_idx = {ba, row, col[5:3], lo};
    endfunction

endpackage

// File: rtl/ddr3_word_ram.sv
// ddr3_word_ram: 2^AW x 16-bit word store with byte enables.
//   clk      - clock
//   we_i     - write enable; be_i selects byte lanes written
//   waddr_i  - write word address
//   wdata_i  - write data
//   be_i     - byte enable (1 = write lane)
//   re_i     - read enable; rdata_o updates one cycle after raddr_i
//   raddr_i  - read word address
//   rdata_o  - registered read data
// Storage has no reset; contents survive a responder reset.
module ddr3_word_ram
    import ddr3_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DQ_W-1:0] wdata_i,
    input  logic [BE_W-1:0] be_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DQ_W-1:0] rdata_o
);

    logic [DQ_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int j = 0; j < BE_W; j++) begin
                if (be_i[j]) mem[waddr_i][j*8 +: 8] <= wdata_i[j*8 +: 8];
            end
        end
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/ddr3_sdram_responder.sv
// ddr3_sdram_responder: behavioural DDR3 device model at command-clock granularity.
// Decodes the command bus, tracks per-bank open rows, mode registers (CL/AL/BL),
// and runs one read or write burst at a time against an internal word store.
// Ports:
//   clk, reset (async, active-low)
//   cs_bar, ras_bar, cas_bar, we_bar, BA[2:0], A[12:0] - command bus
//   DM[1:0], DQ_in[15:0], DQS_in[1:0]                  - write data path
//   DQ_out[15:0], DQS_out[1:0], dq_oe                  - read data path
//   proto_err, err_code[2:0]                           - sticky first protocol error
//   rl[4:0], wl[4:0]                                   - current read / write latency
module ddr3_sdram_responder
    import ddr3_pkg::*;
#(
    parameter int MEM_AW = 11,
    parameter int CWL    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs_bar,
    input  logic            ras_bar,
    input  logic            cas_bar,
    input  logic            we_bar,
    input  logic [2:0]      BA,
    input  logic [12:0]     A,
    input  logic [1:0]      DM,
    input  logic [15:0]     DQ_in,
    input  logic [1:0]      DQS_in,
    output logic [15:0]     DQ_out,
    output logic [1:0]      DQS_out,
    output logic            dq_oe,
    output logic            proto_err,
    output logic [2:0]      err_code,
    output logic [4:0]      rl,
    output logic [4:0]      wl
);

    localparam logic [4:0] CWL_L = 5'(CWL);

    cmd_e cmd;
    assign cmd = decode_cmd(cs_bar, ras_bar, cas_bar, we_bar);

    // Bank and mode state
    logic [7:0]       bank_act_q, bank_act_d;
    logic [7:0][12:0] bank_row_q, bank_row_d;
    logic [4:0]       cl_q, cl_d;
    logic [1:0]       al_mode_q, al_mode_d;
    logic             bc4_q, bc4_d;

    // Burst sequencer; age counts cycles since the command cycle (1 = next cycle)
    bst_e       bst_q, bst_d;
    logic [5:0] age_q, age_d;
    logic [4:0] lat_q, lat_d;
    logic       b_bc4_q, b_bc4_d;
    logic [2:0] b_ba_q, b_ba_d;
    logic [1:0] b_row_q, b_row_d;
    logic [5:0] b_col_q, b_col_d;
    logic       b_ap_q, b_ap_d;

    logic       proto_err_q, proto_err_d;
    err_e       err_code_q, err_code_d;

    logic       err_new;
    err_e       err_cause;

    logic [4:0] al;
    assign al = al_decode(al_mode_q, cl_q);
    assign rl = cl_q + al;
    assign wl = al + CWL_L;

    logic [5:0] lat6, nbeats, last_age;
    logic       busy, in_data, last_beat, rd_fetch;
    logic [2:0] beat, rbeat;

    assign lat6      = {1'b0, lat_q};
    assign nbeats    = b_bc4_q ? 6'd4 : 6'd8;
    assign last_age  = lat6 + nbeats - 6'd1;
    assign busy      = (bst_q != BST_IDLE);
    assign in_data   = busy && (age_q >= lat6) && (age_q <= last_age);
    assign last_beat = busy && (age_q == last_age);
    // Beat numbers fit in 3 bits, so mod-8 subtraction on the low bits is exact.
    assign beat      = age_q[2:0] - lat_q[2:0];
    // Read store is registered: fetch one cycle ahead of the beat on DQ_out.
    assign rbeat     = age_q[2:0] - lat_q[2:0] + 3'd1;
    assign rd_fetch  = (bst_q == BST_RD) && (age_q >= lat6 - 6'd1) && (age_q < last_age);

    logic [WORD_IDX_W-1:0] widx, ridx;
    logic [15:0]           ram_rdata;
    logic                  ram_we;

    assign widx   = word_idx(b_ba_q, b_row_q, b_col_q, beat,  b_bc4_q);
    assign ridx   = word_idx(b_ba_q, b_row_q, b_col_q, rbeat, b_bc4_q);
    assign ram_we = (bst_q == BST_WR) && in_data;

    ddr3_word_ram #(.AW(MEM_AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (MEM_AW'(widx)),
        .wdata_i (DQ_in),
        .be_i    (~DM),
        .re_i    (rd_fetch),
        .raddr_i (MEM_AW'(ridx)),
        .rdata_o (ram_rdata)
    );

    // Outputs come straight from reset-cleared state so reset drops them asynchronously.
    logic rd_data;
    assign rd_data   = (bst_q == BST_RD) && in_data;
    assign dq_oe     = (bst_q == BST_RD) && (age_q >= lat6 - 6'd1) && (age_q <= last_age);
    assign DQ_out    = rd_data ? ram_rdata : 16'h0000;
    assign DQS_out   = (rd_data && !beat[0]) ? 2'b11 : 2'b00;
    assign proto_err = proto_err_q;
    assign err_code  = err_code_q;

    // Write strobe is monitored only; upper open-row bits are kept for state fidelity.
    logic unused_sigs;
    assign unused_sigs = ^{DQS_in, bank_row_q};

    always_comb begin
        bank_act_d  = bank_act_q;
        bank_row_d  = bank_row_q;
        cl_d        = cl_q;
        al_mode_d   = al_mode_q;
        bc4_d       = bc4_q;
        bst_d       = bst_q;
        age_d       = age_q;
        lat_d       = lat_q;
        b_bc4_d     = b_bc4_q;
        b_ba_d      = b_ba_q;
        b_row_d     = b_row_q;
        b_col_d     = b_col_q;
        b_ap_d      = b_ap_q;
        proto_err_d = proto_err_q;
        err_code_d  = err_code_q;
        err_new     = 1'b0;
        err_cause   = ERR_NONE;

        if (busy) begin
            age_d = age_q + 6'd1;
            if (last_beat) bst_d = BST_IDLE;
        end

        case (cmd)
            CMD_ACT: begin
                if (bank_act_q[BA]) begin
                    err_new   = 1'b1;
                    err_cause = ERR_ACT_ACTIVE;
                end else begin
                    bank_act_d[BA] = 1'b1;
                    bank_row_d[BA] = A;
                end
            end
            CMD_PRE: begin
                if (A[10]) bank_act_d     = '0;
                else       bank_act_d[BA] = 1'b0;
            end
            CMD_RD, CMD_WR: begin
                if (!bank_act_q[BA]) begin
                    err_new   = 1'b1;
                    err_cause = ERR_IDLE_BANK;
                end else if (busy) begin
                    err_new   = 1'b1;
                    err_cause = ERR_OVERLAP;
                end else begin
                    bst_d   = (cmd == CMD_RD) ? BST_RD : BST_WR;
                    age_d   = 6'd1;
                    lat_d   = (cmd == CMD_RD) ? rl : wl;
                    b_bc4_d = bc4_q;
                    b_ba_d  = BA;
                    b_row_d = bank_row_q[BA][1:0];
                    b_col_d = A[5:0];
                    b_ap_d  = A[10];
                end
            end
            CMD_MRS: begin
                // Flagged but still applied.
                if (|bank_act_q) begin
                    err_new   = 1'b1;
                    err_cause = ERR_MRS_ACTIVE;
                end
                if (BA == 3'd0) begin
                    cl_d = cl_decode(A[6:4], cl_q);
                    if (A[1:0] == 2'b00)      bc4_d = 1'b0;
                    else if (A[1:0] == 2'b10) bc4_d = 1'b1;
                end else if (BA == 3'd1) begin
                    al_mode_d = A[4:3];
                end
            end
            default: ;
        endcase

        // Auto-precharge: bank goes idle the cycle after the last data beat.
        if (last_beat && b_ap_q) bank_act_d[b_ba_q] = 1'b0;

        if (err_new && !proto_err_q) begin
            proto_err_d = 1'b1;
            err_code_d  = err_cause;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_act_q  <= '0;
            bank_row_q  <= '0;
            cl_q        <= CL_RESET;
            al_mode_q   <= 2'b00;
            bc4_q       <= 1'b0;
            bst_q       <= BST_IDLE;
            age_q       <= '0;
            lat_q       <= '0;
            b_bc4_q     <= 1'b0;
            b_ba_q      <= '0;
            b_row_q     <= '0;
            b_col_q     <= '0;
            b_ap_q      <= 1'b0;
            proto_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            bank_act_q  <= bank_act_d;
            bank_row_q  <= bank_row_d;
            cl_q        <= cl_d;
            al_mode_q   <= al_mode_d;
            bc4_q       <= bc4_d;
            bst_q       <= bst_d;
            age_q       <= age_d;
            lat_q       <= lat_d;
            b_bc4_q     <= b_bc4_d;
            b_ba_q      <= b_ba_d;
            b_row_q     <= b_row_d;
            b_col_q     <= b_col_d;
            b_ap_q      <= b_ap_d;
            proto_err_q <= proto_err_d;
            err_code_q  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_ddr3_sdram_responder.sv
module tb_ddr3_sdram_responder;

    logic        clk;
    logic        reset;
    logic        cs_bar, ras_bar, cas_bar, we_bar;
    logic [2:0]  BA;
    logic [12:0] A;
    logic [1:0]  DM;
    logic [15:0] DQ_in;
    logic [1:0]  DQS_in;
    logic [15:0] DQ_out;
    logic [1:0]  DQS_out;
    logic        dq_oe;
    logic        proto_err;
    logic [2:0]  err_code;
    logic [4:0]  rl, wl;

    ddr3_sdram_responder #(.MEM_AW(11), .CWL(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_bar    (cs_bar),
        .ras_bar   (ras_bar),
        .cas_bar   (cas_bar),
        .we_bar    (we_bar),
        .BA        (BA),
        .A         (A),
        .DM        (DM),
        .DQ_in     (DQ_in),
        .DQS_in    (DQS_in),
        .DQ_out    (DQ_out),
        .DQS_out   (DQS_out),
        .dq_oe     (dq_oe),
        .proto_err (proto_err),
        .err_code  (err_code),
        .rl        (rl),
        .wl        (wl)
    );

    localparam logic [3:0] C_MRS = 4'b0000, C_PRE = 4'b0010, C_ACT = 4'b0011,
                           C_WR  = 4'b0100, C_RD  = 4'b0101;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [1:0]  s;
    } beat_t;

    beat_t sb[$];
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;
    logic  prev_oe = 1'b0;

    logic [15:0] dA    [8];
    logic [1:0]  mA    [8];
    logic [15:0] dB    [8];
    logic [1:0]  mB    [8];
    logic [15:0] exA1  [8];
    logic [15:0] exA2  [8];
    logic [15:0] exWrp [8];
    logic [15:0] exBc4 [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    endtask

    // Monitor: every cycle the DUT drives the bus is a preamble or a scored beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (dq_oe) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_oe: got dq_oe=1 at cycle %0d want 0", cyc);
                end else if (!prev_oe) begin
                    chk("preamble_dqs", 32'(DQS_out), 32'd0);
                    chk("preamble_cyc", cyc, sb[0].cyc - 1);
                end else begin
                    b = sb.pop_front();
                    chk("beat_cyc",  cyc, b.cyc);
                    chk("beat_data", 32'(DQ_out), 32'(b.d));
                    chk("beat_dqs",  32'(DQS_out), 32'(b.s));
                end
            end
            prev_oe = dq_oe;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] c, input logic [2:0] ba, input logic [12:0] a);
        {cs_bar, ras_bar, cas_bar, we_bar} = c;
        BA = ba;
        A  = a;
        tick();
        {cs_bar, ras_bar, cas_bar, we_bar} = 4'b0111;
        BA = 3'd0;
        A  = 13'd0;
    endtask

    task automatic rd(input logic [2:0] ba, input logic [9:0] col, input logic ap,
                      input int n, input int lat, input logic [15:0] ex [8]);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.cyc = cyc + lat + i;
            b.d   = ex[i];
            b.s   = (i % 2 == 0) ? 2'b11 : 2'b00;
            sb.push_back(b);
        end
        drive_cmd(C_RD, ba, {2'b00, ap, col});
    endtask

    task automatic wr(input logic [2:0] ba, input logic [9:0] col, input int lat,
                      input logic [15:0] d [8], input logic [1:0] m [8]);
        drive_cmd(C_WR, ba, {3'b000, col});
        for (int k = 1; k < lat + 8; k++) begin
            if (k >= lat) begin
                DQ_in = d[k-lat];
                DM    = m[k-lat];
            end
            tick();
        end
        DQ_in = 16'h0;
        DM    = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_dq_oe",     32'(dq_oe),     32'd0);
        chk("rst_dq_out",    32'(DQ_out),    32'd0);
        chk("rst_dqs_out",   32'(DQS_out),   32'd0);
        chk("rst_err_code",  32'(err_code),  32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("rel_dq_oe",     32'(dq_oe),     32'd0);
        chk("rel_rl",        32'(rl),        32'd5);
        chk("rel_wl",        32'(wl),        32'd5);
        chk("rel_proto_err", 32'(proto_err), 32'd0);
    endtask

    initial begin
        {cs_bar, ras_bar, cas_bar, we_bar} = 4'b0111;
        BA = 3'd0; A = 13'd0; DM = 2'b00; DQ_in = 16'h0; DQS_in = 2'b00;
        reset = 1'b0;

        dA    = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        mA    = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        dB    = '{16'hDEAD, 16'hDEAD, 16'hAAAA, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
        mB    = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        exA1  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        exA2  = '{16'h1111, 16'h2222, 16'hAA33, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        exWrp = '{16'h6666, 16'h7777, 16'h8888, 16'h1111, 16'h2222, 16'hAA33, 16'h4444, 16'h5555};
        exBc4 = '{16'h7777, 16'h8888, 16'h5555, 16'h6666, 16'h0, 16'h0, 16'h0, 16'h0};

        // Mode registers, write, readback, masked overwrite, wrapped read
        do_reset();
        drive_cmd(C_MRS, 3'd1, 13'h0010);
        chk("al_cl2_rl", 32'(rl), 32'd8);
        drive_cmd(C_MRS, 3'd0, 13'h0110);
        chk("mrs_rl", 32'(rl), 32'd8);
        chk("mrs_wl", 32'(wl), 32'd8);
        drive_cmd(C_ACT, 3'd2, 13'd3);
        wr(3'd2, 10'h008, 8, dA, mA);
        rd(3'd2, 10'h008, 1'b0, 8, 8, exA1);
        repeat (16) tick();
        wr(3'd2, 10'h008, 8, dB, mB);
        rd(3'd2, 10'h008, 1'b0, 8, 8, exA2);
        repeat (16) tick();
        rd(3'd2, 10'h00D, 1'b0, 8, 8, exWrp);
        repeat (16) tick();
        chk("clean_proto_err", 32'(proto_err), 32'd0);

        // READ to idle bank; first cause sticks over a later ACT error
        do_reset();
        drive_cmd(C_RD, 3'd5, 13'h0008);
        chk("idle_rd_err",  32'(proto_err), 32'd1);
        chk("idle_rd_code", 32'(err_code),  32'd1);
        repeat (12) tick();
        drive_cmd(C_ACT, 3'd0, 13'd0);
        drive_cmd(C_ACT, 3'd0, 13'd0);
        chk("sticky_code", 32'(err_code), 32'd1);

        // BC4 read with auto-precharge, then READ to the now-idle bank
        do_reset();
        drive_cmd(C_MRS, 3'd0, 13'h0012);
        chk("bc4_rl", 32'(rl), 32'd5);
        drive_cmd(C_ACT, 3'd2, 13'd3);
        rd(3'd2, 10'h00E, 1'b1, 4, 5, exBc4);
        repeat (8) tick();
        chk("ap_no_err", 32'(proto_err), 32'd0);
        drive_cmd(C_RD, 3'd2, 13'h000E);
        chk("ap_idle_err",  32'(proto_err), 32'd1);
        chk("ap_idle_code", 32'(err_code),  32'd1);
        repeat (12) tick();

        // Reset asserted mid-burst: two beats out, then bus released at once
        do_reset();
        drive_cmd(C_ACT, 3'd2, 13'd3);
        rd(3'd2, 10'h008, 1'b0, 2, 5, exA1);
        repeat (6) tick();
        do_reset();

        // PRE single bank, re-ACT cleanly, then ACT to active bank
        drive_cmd(C_ACT, 3'd0, 13'd0);
        drive_cmd(C_PRE, 3'd0, 13'd0);
        drive_cmd(C_ACT, 3'd0, 13'd0);
        chk("pre_reopen_ok", 32'(proto_err), 32'd0);
        drive_cmd(C_ACT, 3'd0, 13'd0);
        chk("act_act_code", 32'(err_code), 32'd2);

        // Burst overlap: second READ ignored, first burst intact
        do_reset();
        drive_cmd(C_ACT, 3'd2, 13'd3);
        rd(3'd2, 10'h008, 1'b0, 8, 5, exA2);
        drive_cmd(C_RD, 3'd2, 13'h000D);
        chk("overlap_code", 32'(err_code), 32'd3);
        repeat (16) tick();

        // MRS while a bank is open: flagged and still applied (CL=7)
        do_reset();
        drive_cmd(C_ACT, 3'd3, 13'd0);
        drive_cmd(C_PRE, 3'd0, 13'h0400);
        drive_cmd(C_ACT, 3'd3, 13'd0);
        drive_cmd(C_MRS, 3'd0, 13'h0030);
        chk("mrs_act_code", 32'(err_code), 32'd4);
        chk("mrs_act_rl",   32'(rl),       32'd7);
        chk("mrs_act_wl",   32'(wl),       32'd5);

        repeat (4) tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
